ad_responder: RTL and testbench
===============================

// Module: ad_responder
// PURPOSE
//  Synthesizable serial ADC responder: the device side of the SCK/SDIN/SDOUT/CSLD converter link.
//  Samples the master's SCK, CSLD and SDIN in the CLK domain, returns one 16-bit word per frame on SDOUT, and captures the master's 16-bit command word.
//  Used for on-board loopback of the ADC controller without a physical converter, and as a bench model.
// PARAMETERS
//  FRAME_W  16  bits per frame (SCK rising edges per CSLD-low window)
//  DATA_W   10  sample width; returned word = {(FRAME_W-DATA_W)'b0, sample}, MSB first
//  SYNC_N   2   synchronizer flops on SCK, CSLD, SDIN (>=2)
// PORTS
//  CLK           in   1        system clock, all logic on posedge
//  RST_N         in   1        asynchronous, active-low reset
//  SCK           in   1        serial clock from master, idles high
//  CSLD          in   1        frame select from master, active low
//  SDIN          in   1        command bit from master
//  SDOUT         out  1        data bit to master
//  sample_data   in   DATA_W   next conversion value
//  sample_valid  in   1        load sample_data into holding register
//  cmd_word      out  FRAME_W  last complete command word received
//  cmd_valid     out  1        1-CLK pulse: cmd_word updated
//  frame_err     out  1        1-CLK pulse: frame ended with bit count != FRAME_W
// BEHAVIOUR
//  - Reset: SDOUT=0, cmd_word=0, cmd_valid=0, frame_err=0, holding reg=0, FSM=WAIT_HI, sync flops preset to 1 (SCK/CSLD) and 0 (SDIN).
//  - Inputs pass SYNC_N flops plus one edge-detect flop. Every event lags its pin by SYNC_N+1 CLK. SCK half-period must be >= SYNC_N+2 CLK.
//  - Holding reg loads on sample_valid. Snapshot into shift reg on CSLD fall. If sample_valid coincides with the snapshot, the new sample_data is the one snapshotted (bypass).
//  - FSM:
//    WAIT_HI -> IDLE when synced CSLD=1. Entered after reset, so a frame already in progress at reset release is ignored.
//    IDLE -> SHIFT on CSLD fall: load snapshot, SDOUT=word[FRAME_W-1], bit_cnt=0.
//    SHIFT:
//      SCK rise: cmd_shift <= {cmd_shift, SDIN}; bit_cnt++ (saturates at FRAME_W+1).
//      SCK fall with bit_cnt>0: shift data left, zero-fill, SDOUT=new MSB. A fall before the first rise does not shift.
//      CSLD rise -> IDLE: if bit_cnt==FRAME_W then cmd_word<=cmd_shift and cmd_valid pulse; else frame_err pulse, cmd_word unchanged. SDOUT=0 the same cycle.
//  - More than FRAME_W rises: SDOUT shifts zeros, frame ends with frame_err.
//  - SCK/SDIN activity with CSLD high: ignored.
//  - SCK edge and CSLD rise in the same CLK: CSLD rise wins, edge discarded.
//  - cmd_valid and frame_err are never high together.
// CONFIGURATION
//  AD_RESPONDER_TESTPAT_EN defined:
//    internal DATA_W-bit ramp replaces the holding reg as snapshot source.
//    Ramp starts at 0 after reset, +1 after every snapshot, wraps 2^DATA_W-1 -> 0.
//    sample_data/sample_valid ignored.
//  AD_RESPONDER_TESTPAT_EN undefined: snapshot source is the holding reg as above.
// STRUCTURE
//  - Shared package ad_link_pkg: FRAME_W/DATA_W defaults, FSM state encoding (WAIT_HI, IDLE, SHIFT).
//    The ADC controller and this block both use it.
//  - One sub-module ad_sync_edge: SYNC_N synchronizer + rise/fall pulse outputs, instantiated for SCK and CSLD.
//    SDIN uses the synchronizer only.
//  - Everything else lives in ad_responder.
// TESTING
//  1) sample_valid with 10'h2A5, then a 16-bit frame, SCK half-period 128 CLK:
//     master reads 16'h02A5 MSB first, no frame_err.
//  2) SDIN drives 16'hC3A1 in the same frame:
//     cmd_valid pulse exactly SYNC_N+1 CLK after CSLD rise, cmd_word=16'hC3A1.
//  3) CSLD rises after 9 SCK rises:
//     frame_err pulse, cmd_word keeps the previous value, SDOUT=0.
//     The next full frame returns correct data.
//  4) 18 SCK rises in one frame:
//     bits 16-17 read 0, frame_err pulse, no cmd_valid.
//  5) RST_N low mid-frame, released while CSLD still low:
//     no response or pulses for that frame; the following frame is correct.
//  6) AD_RESPONDER_TESTPAT_EN: four frames return 0,1,2,3.
//     With DATA_W=2, the 5th frame returns 0 (wrap).

Source files
------------

// File: rtl/ad_link_pkg.sv
// Shared definitions for the serial ADC link (controller and responder):
// default frame/sample widths and the link FSM state encoding.
package ad_link_pkg;

    localparam int unsigned FRAME_W_DEF = 16;
    localparam int unsigned DATA_W_DEF  = 10;
    localparam int unsigned SYNC_N_DEF  = 2;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } link_state_e;

endpackage

// File: rtl/ad_sync_edge.sv
// Multi-flop synchronizer with an edge-detect flop; rise/fall pulses are one
// CLK wide and valid in the cycle the synchronized level changes.
module ad_sync_edge #(
    parameter int unsigned SYNC_N  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_N-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chain_q <= {SYNC_N{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_N-2:0], din};
            prev_q  <= chain_q[SYNC_N-1];
        end
    end

    assign level  = chain_q[SYNC_N-1];
    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;

endmodule

// File: rtl/ad_responder.sv
// Device side of the SCK/SDIN/SDOUT/CSLD ADC link: returns one zero-padded
// sample per frame and captures the master's command word.
// Define AD_RESPONDER_TESTPAT_EN to replace the sample holding register with an internal ramp.
module ad_responder
    import ad_link_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SYNC_N  = SYNC_N_DEF
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               SCK,
    input  logic               CSLD,
    input  logic               SDIN,
    output logic               SDOUT,
    input  logic [DATA_W-1:0]  sample_data,
    input  logic               sample_valid,
    output logic [FRAME_W-1:0] cmd_word,
    output logic               cmd_valid,
    output logic               frame_err
);

    localparam int unsigned CNT_W    = $clog2(FRAME_W + 2);
    localparam int unsigned SETTLE_W = $clog2(SYNC_N + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(FRAME_W + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SYNC_N);

    logic sck_lvl, sck_rise_c, sck_fall_c;
    logic csld_lvl, csld_rise_c, csld_fall_c;

    ad_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_sck (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .din    (SCK),
        .level  (sck_lvl),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    ad_sync_edge #(.SYNC_N(SYNC_N), .RST_VAL(1'b1)) u_sync_csld (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .din    (CSLD),
        .level  (csld_lvl),
        .rise_c (csld_rise_c),
        .fall_c (csld_fall_c)
    );

    // SDIN needs no edge detect; same depth keeps it aligned with the SCK edge pulses.
    logic [SYNC_N-1:0] sdin_q;
    logic              sdin_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sdin_q <= '0;
        end else begin
            sdin_q <= {sdin_q[SYNC_N-2:0], SDIN};
        end
    end

    assign sdin_s = sdin_q[SYNC_N-1];

    link_state_e         state_q;
    logic                snap_take_c;
    logic [DATA_W-1:0]   snap_src_c;
    logic [FRAME_W-1:0]  snap_word_c;

    assign snap_take_c = (state_q == IDLE) && csld_fall_c;
    assign snap_word_c = FRAME_W'(snap_src_c);

`ifdef AD_RESPONDER_TESTPAT_EN
    logic [DATA_W-1:0] ramp_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ramp_q <= '0;
        end else if (snap_take_c) begin
            ramp_q <= ramp_q + DATA_W'(1);
        end
    end

    assign snap_src_c = ramp_q;
`else
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
        end else if (sample_valid) begin
            hold_q <= sample_data;
        end
    end

    // A sample arriving in the snapshot cycle is taken directly.
    assign snap_src_c = sample_valid ? sample_data : hold_q;
`endif

    logic [SETTLE_W-1:0] settle_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [FRAME_W-2:0]  data_q;
    logic [FRAME_W-1:0]  cmd_shift_q;

    // settle_q keeps WAIT_HI from trusting the synchronizer preset before the pin has propagated.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= WAIT_HI;
            settle_q    <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            cmd_shift_q <= '0;
            cmd_word    <= '0;
            cmd_valid   <= 1'b0;
            frame_err   <= 1'b0;
            SDOUT       <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (settle_q != SETTLE_END) begin
                settle_q <= settle_q + SETTLE_W'(1);
            end
            case (state_q)
                WAIT_HI: begin
                    if (settle_q == SETTLE_END && csld_lvl) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (csld_fall_c) begin
                        state_q   <= SHIFT;
                        data_q    <= snap_word_c[FRAME_W-2:0];
                        SDOUT     <= snap_word_c[FRAME_W-1];
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    // CSLD rise has priority over a coincident SCK edge.
                    if (csld_rise_c) begin
                        state_q <= IDLE;
                        SDOUT   <= 1'b0;
                        if (bit_cnt_q == CNT_FULL) begin
                            cmd_word  <= cmd_shift_q;
                            cmd_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sck_rise_c) begin
                        cmd_shift_q <= {cmd_shift_q[FRAME_W-2:0], sdin_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sck_fall_c && bit_cnt_q != '0) begin
                        SDOUT  <= data_q[FRAME_W-2];
                        data_q <= {data_q[FRAME_W-3:0], 1'b0};
                    end
                end
                default: state_q <= WAIT_HI;
            endcase
        end
    end

    // SCK level itself is not needed; only its edges drive the frame.
    logic unused_sck_lvl;
    assign unused_sck_lvl = sck_lvl;

endmodule

// File: tb/tb_ad_responder.sv
// Randomized bench for ad_responder: a behavioural master drives frames and a
// frame-level model predicts read data, command capture and error pulses.
module tb_ad_responder;
    import ad_link_pkg::*;

    localparam int unsigned FW = FRAME_W_DEF;
    localparam int unsigned DW = DATA_W_DEF;
    localparam int unsigned SN = SYNC_N_DEF;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SCK = 1'b1;
    logic          CSLD = 1'b1;
    logic          SDIN = 1'b0;
    logic          SDOUT;
    logic [DW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic [FW-1:0] cmd_word;
    logic          cmd_valid;
    logic          frame_err;

    ad_responder dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .SCK          (SCK),
        .CSLD         (CSLD),
        .SDIN         (SDIN),
        .SDOUT        (SDOUT),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .cmd_word     (cmd_word),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;

    logic [FW-1:0] m_cmd = '0;
    logic [DW-1:0] m_hold = '0;
    logic [DW-1:0] m_ramp = '0;

    always @(negedge CLK) begin
        if (cmd_valid) cv_cnt++;
        if (frame_err) fe_cnt++;
        if (cmd_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic load_sample(input logic [DW-1:0] v);
        sample_data  = v;
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        m_hold = v;
    endtask

    // One master frame of n_rises SCK cycles with half-period h.
    task automatic run_frame(input int n_rises, input int h, input logic [FW-1:0] cmd,
                             input bit byp, input logic [DW-1:0] byp_val, input string tag);
        logic [DW-1:0] src;
        logic [FW-1:0] word;
        logic [31:0]   rd, exp_rd;
        int            cv0, fe0, lat_cv, lat_fe;
        bit            full;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        rd = '0;
        exp_rd = '0;
        CSLD = 1'b0;
        if (byp) begin
            tick(SN);
            sample_data  = byp_val;
            sample_valid = 1'b1;
            tick(1);
            sample_valid = 1'b0;
            tick(h - SN - 1);
        end else begin
            tick(h);
        end
`ifdef AD_RESPONDER_TESTPAT_EN
        src = m_ramp;
        m_ramp = m_ramp + 1'b1;
`else
        if (byp) m_hold = byp_val;
        src = m_hold;
`endif
        word = FW'(src);
        for (int i = 0; i < n_rises; i++) begin
            SCK  = 1'b0;
            SDIN = (i < int'(FW)) ? cmd[FW-1-i] : 1'($urandom);
            tick(h);
            rd = {rd[30:0], SDOUT};
            exp_rd = {exp_rd[30:0], (i < int'(FW)) ? word[FW-1-i] : 1'b0};
            SCK = 1'b1;
            tick(h);
        end
        CSLD = 1'b1;
        lat_cv = -1;
        lat_fe = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (cmd_valid && lat_cv < 0) lat_cv = k;
            if (frame_err && lat_fe < 0) lat_fe = k;
        end
        full = (n_rises == int'(FW));
        if (full) m_cmd = cmd;
        if (n_rises > 0) check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_lat"}, full ? lat_cv : lat_fe, SN + 1);
        check({tag, "_ncv"}, cv_cnt - cv0, full ? 1 : 0);
        check({tag, "_nfe"}, fe_cnt - fe0, full ? 0 : 1);
        check({tag, "_cmd"}, 32'(cmd_word), 32'(m_cmd));
        check({tag, "_sdout0"}, 32'(SDOUT), 0);
    endtask

    initial begin
        int cv0, fe0, n, h;
        bit hi_seen;
        logic [FW-1:0] c;

        tick(3);
        check("rst_sdout", 32'(SDOUT), 0);
        check("rst_cmd", 32'(cmd_word), 0);
        check("rst_cv", 32'(cmd_valid), 0);
        check("rst_fe", 32'(frame_err), 0);
        RST_N = 1'b1;
        tick(6);

        // Sample 0x2A5 with command 0xC3A1 at a slow SCK.
        load_sample(10'h2A5);
        run_frame(16, 128, 16'hC3A1, 1'b0, '0, "t1");

        // Short frame, then a full one.
        run_frame(9, 6, 16'($urandom), 1'b0, '0, "short");
        load_sample(DW'($urandom));
        run_frame(16, 5, 16'($urandom), 1'b0, '0, "after_short");

        // Overlong frame shifts zeros and errors.
        run_frame(18, 4, 16'($urandom), 1'b0, '0, "long");

        // Sample arriving in the snapshot cycle wins.
        load_sample(DW'($urandom));
        run_frame(16, 6, 16'($urandom), 1'b1, DW'($urandom), "bypass");

        // Activity with CSLD high is ignored.
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        hi_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            SCK  = ~SCK;
            SDIN = 1'($urandom);
            tick(5);
            if (SDOUT) hi_seen = 1'b1;
        end
        SCK = 1'b1;
        tick(8);
        check("idle_pulses", (cv_cnt - cv0) + (fe_cnt - fe0), 0);
        check("idle_sdout", 32'(hi_seen), 0);
        check("idle_cmd", 32'(cmd_word), 32'(m_cmd));

        // Reset mid-frame, released while CSLD is still low.
        load_sample(DW'($urandom));
        CSLD = 1'b0;
        tick(6);
        for (int i = 0; i < 3; i++) begin
            SCK = 1'b0; SDIN = 1'($urandom); tick(6);
            SCK = 1'b1; tick(6);
        end
        SCK = 1'b0;
        RST_N = 1'b0;
        tick(2);
        m_cmd = '0;
        m_hold = '0;
        m_ramp = '0;
        check("mid_rst_sdout", 32'(SDOUT), 0);
        check("mid_rst_cmd", 32'(cmd_word), 0);
        RST_N = 1'b1;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        hi_seen = 1'b0;
        tick(6);
        for (int i = 0; i < 16; i++) begin
            SCK = 1'b1; SDIN = 1'($urandom); tick(6);
            if (SDOUT) hi_seen = 1'b1;
            SCK = 1'b0; tick(6);
            if (SDOUT) hi_seen = 1'b1;
        end
        SCK = 1'b1;
        tick(6);
        CSLD = 1'b1;
        tick(12);
        check("rst_frame_pulses", (cv_cnt - cv0) + (fe_cnt - fe0), 0);
        check("rst_frame_sdout", 32'(hi_seen), 0);
        check("rst_frame_cmd", 32'(cmd_word), 0);
        load_sample(DW'($urandom));
        run_frame(16, 5, 16'($urandom), 1'b0, '0, "post_rst");

        // Randomized frames.
        for (int f = 0; f < 24; f++) begin
            n = ($urandom_range(0, 3) != 0) ? int'(FW) : int'($urandom_range(0, FW + 2));
            h = int'($urandom_range(SN + 2, 9));
            c = 16'($urandom);
            if ($urandom_range(0, 1) != 0) load_sample(DW'($urandom));
            run_frame(n, h, c, 1'($urandom), DW'($urandom), $sformatf("rnd%0d", f));
        end

        check("never_both", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
